// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM state encoding and the divide-by-zero quotient constant.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  // Wide enough for any supported WIDTH; users slice the low WIDTH bits.
  localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shared 2*WIDTH shift register does shift-add multiply or restoring divide.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Handshake: start is taken only on an edge where busy=0 (IDLE), with no
  // queuing. busy stays high for WIDTH+1 cycles after that edge; busy falls
  // on the edge that raises done, and done is a one-cycle pulse with hi/lo
  // already holding the result. start during the done cycle is accepted.

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div0;

  logic               signed_op;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot_mag;
  logic [WIDTH-1:0]   rem_mag;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: if (start) state_nxt = ST_CALC;
      ST_CALC: if (cnt == LAST) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    rs_mag    = (signed_op && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    rt_mag    = (signed_op && rt_data[WIDTH-1]) ? -rt_data : rt_data;
  end

  // Divide keeps the bit shifted out of the partial remainder (WIDTH+1-bit
  // trial) so divisors with the top bit set still compare correctly.
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    sub_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    if (is_div) begin
      if (sub_diff[WIDTH]) acc_step = {acc[2*WIDTH-2:0], 1'b0};
      else                 acc_step = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {add_sum, acc[WIDTH-1:1]};
    end
  end

  // With a zero divisor every trial succeeds, so the remainder half ends up
  // holding |rs|; re-signing it by sign(rs) restores rs_data exactly.
  always_comb begin
    prod     = neg_res ? -acc : acc;
    quot_mag = acc[WIDTH-1:0];
    rem_mag  = acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      res_hi = neg_rem ? -rem_mag : rem_mag;
      if (div0)         res_lo = DIV0_QUOT[WIDTH-1:0];
      else if (neg_res) res_lo = -quot_mag;
      else              res_lo = quot_mag;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt     <= '0;
            acc     <= {{WIDTH{1'b0}}, rs_mag};
            opnd    <= rt_mag;
            is_div  <= (op == OP_DIV) || (op == OP_DIVU);
            neg_res <= signed_op && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_rem <= signed_op && rs_data[WIDTH-1];
            div0    <= ((op == OP_DIV) || (op == OP_DIVU)) && (rt_data == '0);
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        ST_CALC: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        ST_FIX: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// operations scored against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         start   = 1'b0;
  logic [1:0]   op      = 2'b00;
  logic [W-1:0] rs_data = '0;
  logic [W-1:0] rt_data = '0;
  logic         hi_we   = 1'b0;
  logic         lo_we   = 1'b0;
  logic [W-1:0] wdata   = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  logic [2*W-1:0] exp_q[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int     ia, ib, q, r;
    longint la, lb, p;
    ia = a;
    ib = b;
    la = ia;
    lb = ib;
    case (o)
      2'b00: begin
        p = la * lb;
        return p;
      end
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = ia / ib;
        r = ia % ib;
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one op, scrambles operands after the start edge, waits for done.
  // Returns in the done cycle so a following call starts during done.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] e;
    int cyc;
    int busy_low;
    exp_q.push_back(model(o, a, b));
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    tick();
    start = 1'b0; rs_data = $urandom; rt_data = $urandom;
    check("busy_after_start", busy, 1);
    cyc = 0;
    busy_low = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
      if (!done && !busy) busy_low++;
    end
    check("done_latency", cyc, 33);
    check("busy_during_op", busy_low, 0);
    check("busy_at_done", busy, 0);
    e = exp_q.pop_front();
    check("result", {hi, lo}, e);
  endtask

  typedef struct {
    logic [1:0]   o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eh;
    logic [W-1:0] el;
  } vec_t;

  // ---------------- stimulus ----------------
  initial begin
    vec_t vecs[6];
    int dones, first, cyc;
    logic [W-1:0] a, b;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};

    // reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hilo", {hi, lo}, 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_hilo", {hi, lo}, 64'h0);

    // directed corner cases, also cross-checking the model
    foreach (vecs[i]) begin
      check("model_directed", model(vecs[i].o, vecs[i].a, vecs[i].b), {vecs[i].eh, vecs[i].el});
      run_op(vecs[i].o, vecs[i].a, vecs[i].b);
      check("directed", {hi, lo}, {vecs[i].eh, vecs[i].el});
    end
    tick();
    check("done_one_cycle", done, 0);

    // second start mid-operation is ignored
    op = 2'b11; rs_data = 32'd5; rt_data = 32'd0; start = 1'b1;
    tick();
    dones = 0;
    first = -1;
    for (int i = 1; i <= 45; i++) begin
      if (i == 10) begin
        start = 1'b1; op = 2'b01; rs_data = 32'd3; rt_data = 32'd4;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        dones++;
        if (first < 0) first = i;
      end
    end
    check("midstart_dones", dones, 1);
    check("midstart_latency", first, 33);
    check("midstart_result", {hi, lo}, {32'd5, 32'hFFFF_FFFF});

    // async reset mid-operation
    op = 2'b01; rs_data = 32'd3; rt_data = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_hilo", {hi, lo}, 64'h0);
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);
    lo_we = 1'b1; wdata = 32'h1234_5678;
    tick();
    lo_we = 1'b0;
    check("mtlo", lo, 32'h1234_5678);

    // MTHI in idle, then with start in the same cycle
    hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    tick();
    hi_we = 1'b0;
    check("mthi_idle", hi, 32'hA5A5_A5A5);
    hi_we = 1'b1; wdata = 32'h1111_1111;
    op = 2'b01; rs_data = 32'd2; rt_data = 32'd3; start = 1'b1;
    tick();
    hi_we = 1'b0; start = 1'b0;
    check("mthi_with_start", hi, 32'hA5A5_A5A5);
    cyc = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    check("mthi_start_result", {hi, lo}, {32'd0, 32'd6});

    // MTHI while busy is ignored
    lo_we = 1'b1; hi_we = 1'b1; wdata = 32'hCAFE_F00D;
    tick();
    lo_we = 1'b0; hi_we = 1'b0;
    check("mt_both", {hi, lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});
    op = 2'b01; rs_data = 32'd3; rt_data = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    cyc = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
      if (cyc == 5) check("mthi_busy", hi, 32'hCAFE_F00D);
      if (cyc == 20) hi_we = 1'b0;
    end
    check("mthi_busy_latency", cyc, 33);
    check("mthi_busy_result", {hi, lo}, {32'd0, 32'd12});

    // randomized back-to-back operations
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(0, 300);
        1:       a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2, 3:    b = $urandom_range(1, 50);
        default: b = $urandom;
      endcase
      run_op(2'($urandom_range(0, 3)), a, b);
    end
    tick();
    check("final_done_low", done, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
